// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - debounced 4x4 matrix keypad scanner with press/hold/release FSM
module keypad_scan #(
   parameter int SCAN_DIV = 50000,
   parameter int DEB_CNT  = 500000
) (
   input  logic       clk1,
   input  logic       rst,
   input  logic [3:0] fil,
   output logic [3:0] col,
   output logic [3:0] num,
   output logic       valid,
   output logic       pressed
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(DEB_CNT);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEB_CNT - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t        state, state_n;
   logic [3:0]    sync1, fs;
   logic [DW-1:0] dwell, dwell_n;
   logic [BW-1:0] deb, deb_n;
   logic [3:0]    cand_fil, cand_fil_n;
   logic [3:0]    col_n, num_n;
   logic          valid_n, pressed_n;
   logic          fs_onehot;

   // Column is frozen while a candidate is debounced, so the live col is the candidate column.
   function automatic logic [3:0] key_code(input logic [3:0] c, input logic [3:0] f);
      logic [3:0] code;
      code = 4'h0;
      case ({c, f})
         8'b0001_0001: code = 4'h1;
         8'b0001_0010: code = 4'h2;
         8'b0001_0100: code = 4'h3;
         8'b0001_1000: code = 4'hA;
         8'b0010_0001: code = 4'h4;
         8'b0010_0010: code = 4'h5;
         8'b0010_0100: code = 4'h6;
         8'b0010_1000: code = 4'hB;
         8'b0100_0001: code = 4'h7;
         8'b0100_0010: code = 4'h8;
         8'b0100_0100: code = 4'h9;
         8'b0100_1000: code = 4'hC;
         8'b1000_0001: code = 4'hE;
         8'b1000_0010: code = 4'h0;
         8'b1000_0100: code = 4'hF;
         8'b1000_1000: code = 4'hD;
         default:      code = 4'h0;
      endcase
      return code;
   endfunction

   assign fs_onehot = (fs != 4'b0000) && ((fs & (fs - 4'd1)) == 4'b0000);

   // Two-flop synchronizer for the asynchronous, bouncing row lines.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         sync1 <= 4'b0000;
         fs    <= 4'b0000;
      end else begin
         sync1 <= fil;
         fs    <= sync1;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state    <= SCAN;
         dwell    <= '0;
         deb      <= '0;
         cand_fil <= 4'b0000;
         col      <= 4'b0001;
         num      <= 4'h0;
         valid    <= 1'b0;
         pressed  <= 1'b0;
      end else begin
         state    <= state_n;
         dwell    <= dwell_n;
         deb      <= deb_n;
         cand_fil <= cand_fil_n;
         col      <= col_n;
         num      <= num_n;
         valid    <= valid_n;
         pressed  <= pressed_n;
      end
   end

   // Next-state logic: scan columns, debounce one press, wait for a debounced release.
   always_comb begin
      state_n    = state;
      dwell_n    = dwell;
      deb_n      = deb;
      cand_fil_n = cand_fil;
      col_n      = col;
      num_n      = num;
      valid_n    = 1'b0;
      pressed_n  = pressed;
      case (state)
         SCAN: begin
            if (dwell == DWELL_LAST) begin
               dwell_n = '0;
               if (fs_onehot) begin
                  cand_fil_n = fs;
                  deb_n      = '0;
                  state_n    = DEBOUNCE;
               end else begin
                  col_n = {col[2:0], col[3]};
               end
            end else begin
               dwell_n = dwell + DW'(1);
            end
         end
         DEBOUNCE: begin
            if (fs == cand_fil) begin
               if (deb == DEB_LAST) begin
                  deb_n     = '0;
                  num_n     = key_code(col, cand_fil);
                  valid_n   = 1'b1;
                  pressed_n = 1'b1;
                  state_n   = HELD;
               end else begin
                  deb_n = deb + BW'(1);
               end
            end else begin
               deb_n   = '0;
               dwell_n = '0;
               col_n   = {col[2:0], col[3]};
               state_n = SCAN;
            end
         end
         HELD: begin
            if (fs == 4'b0000) begin
               deb_n   = '0;
               state_n = RELEASE;
            end
         end
         RELEASE: begin
            if (fs == 4'b0000) begin
               if (deb == DEB_LAST) begin
                  deb_n     = '0;
                  dwell_n   = '0;
                  pressed_n = 1'b0;
                  col_n     = {col[2:0], col[3]};
                  state_n   = SCAN;
               end else begin
                  deb_n = deb + BW'(1);
               end
            end else begin
               deb_n   = '0;
               state_n = HELD;
            end
         end
         default: state_n = SCAN;
      endcase
   end
endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan against a behavioural keypad model
module tb_keypad_scan;
   localparam int SD = 4;
   localparam int DB = 8;
   localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

   logic       clk1 = 1'b0;
   logic       rst;
   logic [3:0] fil;
   logic [3:0] col, num;
   logic       valid, pressed;

   int errors = 0;
   int checks = 0;

   always #5 clk1 = ~clk1;

   keypad_scan #(.SCAN_DIV(SD), .DEB_CNT(DB)) dut (
      .clk1(clk1), .rst(rst), .fil(fil),
      .col(col), .num(num), .valid(valid), .pressed(pressed)
   );

   // Reference model: column index, mode, plain integer counters, key lookup table.
   int         keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
   int         m_ci, m_mode, m_dwell, m_cnt, m_row;
   logic [3:0] m_s1, m_fs, m_num;
   logic       m_valid, m_pressed;

   task automatic model_reset();
      m_ci = 0; m_mode = M_SCAN; m_dwell = 0; m_cnt = 0; m_row = 0;
      m_s1 = 4'b0; m_fs = 4'b0; m_num = 4'h0; m_valid = 1'b0; m_pressed = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] f);
      m_valid = 1'b0;
      case (m_mode)
         M_SCAN: begin
            if (m_dwell == SD - 1) begin
               m_dwell = 0;
               if ($countones(m_fs) == 1) begin
                  for (int b = 0; b < 4; b++) if (m_fs[b]) m_row = b;
                  m_cnt = 0;
                  m_mode = M_DEB;
               end else m_ci = (m_ci + 1) % 4;
            end else m_dwell++;
         end
         M_DEB: begin
            if (m_fs == (4'b0001 << m_row)) begin
               m_cnt++;
               if (m_cnt == DB) begin
                  m_num = 4'(keymap[m_ci * 4 + m_row]);
                  m_valid = 1'b1; m_pressed = 1'b1; m_cnt = 0; m_mode = M_HELD;
               end
            end else begin
               m_cnt = 0; m_dwell = 0; m_ci = (m_ci + 1) % 4; m_mode = M_SCAN;
            end
         end
         M_HELD: if (m_fs == 4'b0) begin m_cnt = 0; m_mode = M_REL; end
         default: begin
            if (m_fs == 4'b0) begin
               m_cnt++;
               if (m_cnt == DB) begin
                  m_pressed = 1'b0; m_cnt = 0; m_dwell = 0;
                  m_ci = (m_ci + 1) % 4; m_mode = M_SCAN;
               end
            end else begin
               m_cnt = 0; m_mode = M_HELD;
            end
         end
      endcase
      m_fs = m_s1;
      m_s1 = f;
   endtask

   function automatic logic [9:0] exp_vec();
      return {4'b0001 << m_ci, m_num, m_valid, m_pressed};
   endfunction

   // Physical keypad: the row line of key (ci, ri) is driven only while its column is driven.
   function automatic logic [3:0] kp(input int ci, input int ri);
      if (m_ci == ci) return 4'b0001 << ri;
      return 4'b0000;
   endfunction

   task automatic step(input logic [3:0] f);
      fil = f;
      @(posedge clk1);
      #1;
      model_step(f);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 6; i++) begin
         step(4'b0);
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL pre_reset%0d: dut=%h model=%h", i, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
      end
      #2 rst = 1'b1;
      #1;
      if ({col, num, valid, pressed} !== 10'b0001_0000_0_0) begin
         errors++; $display("FAIL reset_async: got=%h want=%h", {col, num, valid, pressed}, 10'b0001_0000_0_0);
      end
      checks++;
      @(posedge clk1);
      #1;
      rst = 1'b0;
      model_reset();
      for (int i = 1; i <= 17; i++) begin
         logic [3:0] expc;
         step(4'b0);
         expc = 4'b0001 << ((i / SD) % 4);
         if (col !== expc) begin
            errors++; $display("FAIL dwell%0d: col=%b want=%b", i, col, expc);
         end
         checks++;
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL reset_scan%0d: dut=%h model=%h", i, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_press_5();
      int nv = 0;
      int first0 = -1;
      logic [3:0] got = 4'hX;
      logic held_ok = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step(kp(1, 1));
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL press5_%0d: dut=%h model=%h", i, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
         if (valid === 1'b1) begin nv++; got = num; end
         if (nv > 0 && (col !== 4'b0010 || pressed !== 1'b1)) held_ok = 1'b0;
      end
      if (nv !== 1) begin errors++; $display("FAIL press5_count: got=%0d want=1", nv); end
      checks++;
      if (got !== 4'h5) begin errors++; $display("FAIL press5_num: got=%h want=5", got); end
      checks++;
      if (held_ok !== 1'b1) begin errors++; $display("FAIL press5_hold: col/pressed changed while held, got=%b want=1", held_ok); end
      checks++;
      for (int i = 0; i < 20; i++) begin
         step(4'b0);
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL release5_%0d: dut=%h model=%h", i, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
         if (first0 < 0 && pressed === 1'b0) first0 = i;
      end
      if (first0 !== 10) begin errors++; $display("FAIL release5_time: got=%0d want=10", first0); end
      checks++;
   endtask

   task automatic test_bounce_8();
      int guard = 0;
      int nv = 0;
      logic seen = 1'b0;
      while (m_mode != M_DEB && guard < 40) begin
         step(kp(2, 1));
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL bounce_pre%0d: dut=%h model=%h", guard, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
         guard++;
      end
      if (guard >= 40) begin errors++; $display("FAIL bounce_enter: got=timeout want=debounce"); end
      checks++;
      for (int k = 0; k < 22; k++) begin
         logic [3:0] f;
         f = (k < 12 && ((k / 3) % 2 == 0)) ? 4'b0010 : 4'b0000;
         step(f);
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL bounce_%0d: dut=%h model=%h", k, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
         if (valid === 1'b1) nv++;
         if (!seen && m_mode == M_SCAN) begin
            seen = 1'b1;
            if (col !== 4'b1000) begin errors++; $display("FAIL bounce_col: got=%b want=1000", col); end
            checks++;
         end
      end
      if (nv !== 0) begin errors++; $display("FAIL bounce_valid: got=%0d want=0", nv); end
      checks++;
   endtask

   task automatic test_release_bounce_d();
      int nv = 0;
      int first0 = -1;
      logic [3:0] got = 4'hX;
      logic [3:0] seq [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
      for (int i = 0; i < 45; i++) begin
         step(kp(3, 3));
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL keyd_%0d: dut=%h model=%h", i, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
         if (valid === 1'b1) begin nv++; got = num; end
      end
      for (int i = 0; i < 24; i++) begin
         step(i < 4 ? seq[i] : 4'b0000);
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL keyd_rel%0d: dut=%h model=%h", i, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
         if (valid === 1'b1) nv++;
         if (i >= 4 && first0 < 0 && pressed === 1'b0) first0 = i - 4;
      end
      if (nv !== 1) begin errors++; $display("FAIL keyd_count: got=%0d want=1", nv); end
      checks++;
      if (got !== 4'hD) begin errors++; $display("FAIL keyd_num: got=%h want=d", got); end
      checks++;
      if (first0 !== 10) begin errors++; $display("FAIL keyd_release_time: got=%0d want=10", first0); end
      checks++;
   endtask

   task automatic test_ghost();
      int nv = 0;
      int run = 0;
      int max_run = 0;
      for (int i = 0; i < 40; i++) begin
         step(m_ci == 0 ? 4'b0011 : 4'b0000);
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL ghost_%0d: dut=%h model=%h", i, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
         if (valid === 1'b1) nv++;
         run = (col === 4'b0001) ? run + 1 : 0;
         if (run > max_run) max_run = run;
      end
      if (nv !== 0) begin errors++; $display("FAIL ghost_valid: got=%0d want=0", nv); end
      checks++;
      if (max_run > SD) begin errors++; $display("FAIL ghost_dwell: got=%0d want<=%0d", max_run, SD); end
      checks++;
   endtask

   task automatic test_reset_mid_press();
      int nv = 0;
      logic [3:0] got = 4'hX;
      for (int i = 0; i < 45; i++) begin
         step(kp(3, 2));
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL keyf_%0d: dut=%h model=%h", i, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
      end
      if (pressed !== 1'b1) begin errors++; $display("FAIL keyf_held: got=%b want=1", pressed); end
      checks++;
      #2 rst = 1'b1;
      #1;
      if ({col, num, valid, pressed} !== 10'b0001_0000_0_0) begin
         errors++; $display("FAIL keyf_reset: got=%h want=%h", {col, num, valid, pressed}, 10'b0001_0000_0_0);
      end
      checks++;
      @(posedge clk1);
      #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 45; i++) begin
         step(kp(3, 2));
         if ({col, num, valid, pressed} !== exp_vec()) begin
            errors++; $display("FAIL keyf_again%0d: dut=%h model=%h", i, {col, num, valid, pressed}, exp_vec());
         end
         checks++;
         if (valid === 1'b1) begin nv++; got = num; end
      end
      if (nv !== 1) begin errors++; $display("FAIL keyf_count: got=%0d want=1", nv); end
      checks++;
      if (got !== 4'hF) begin errors++; $display("FAIL keyf_num: got=%h want=f", got); end
      checks++;
      for (int i = 0; i < 20; i++) step(4'b0);
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int k, hold, gap;
         k    = $urandom_range(0, 15);
         hold = $urandom_range(20, 60);
         gap  = $urandom_range(12, 30);
         for (int i = 0; i < hold + gap; i++) begin
            logic [3:0] f;
            if (i >= hold) f = 4'b0000;
            else if ($urandom_range(0, 7) == 0) f = 4'($urandom_range(0, 15));
            else f = kp(k / 4, k % 4);
            step(f);
            if ({col, num, valid, pressed} !== exp_vec()) begin
               errors++; $display("FAIL random%0d_%0d: dut=%h model=%h", it, i, {col, num, valid, pressed}, exp_vec());
            end
            checks++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      fil = 4'b0000;
      model_reset();
      @(posedge clk1);
      @(posedge clk1);
      #1;
      rst = 1'b0;
      model_reset();
      test_reset();
      test_press_5();
      test_bounce_8();
      for (int i = 0; i < 20; i++) step(4'b0);
      test_release_bounce_d();
      test_ghost();
      test_reset_mid_press();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
